etroc_multi_link_monitor: RTL and testbench

ETROC_MULTI_LINK_MONITOR -- requirements
Module: etroc_multi_link_monitor

---
 rtl/etroc_multi_link_monitor.sv | 232 +++++++++++++++++++++++
 tb/tb_etroc_multi_link_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/etroc_multi_link_monitor.sv
// ETROC multi-link monitor.
// Counts header, data and trigger events per link over a fixed statistics
// window, tracks lock losses per link, and presents the statistics of one
// selected link on registered outputs.
module etroc_multi_link_monitor #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 32,
    parameter int TICK_CLOCKS = 40000000,
    parameter int REFRESH_W   = 16,
    parameter int SEL_W       = 2
) (
    input  logic                 clk40,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 enable,
    input  logic [SEL_W-1:0]     ch_sel,
    input  logic [NCH-1:0]       link_valid,
    input  logic [2*NCH-1:0]     link_type,
    input  logic [NCH-1:0]       link_aligned,
    input  logic [NCH-1:0]       trig_synched,
    input  logic [NCH-1:0]       trig_pulse,
    output logic [CNT_W-1:0]     header_count,
    output logic [CNT_W-1:0]     data_count,
    output logic [CNT_W-1:0]     trig_count,
    output logic [CNT_W-1:0]     unlock_count,
    output logic [REFRESH_W-1:0] refresh_count,
    output logic                 tick,
    output logic [NCH-1:0]       locked_mask,
    output logic                 any_saturated
);

    localparam int                 TIMER_W    = (TICK_CLOCKS > 1) ? $clog2(TICK_CLOCKS) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TICK_CLOCKS - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

    localparam logic [1:0] TYPE_HEADER = 2'b00;
    localparam logic [1:0] TYPE_DATA   = 2'b01;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    logic [TIMER_W-1:0]   r_timer;
    logic                 r_tick;
    logic [REFRESH_W-1:0] r_refresh;
    logic [NCH-1:0]       r_locked_mask;
    logic                 r_any_sat;

    logic [CNT_W-1:0] r_hdr_acc [NCH];
    logic [CNT_W-1:0] r_dat_acc [NCH];
    logic [CNT_W-1:0] r_trg_acc [NCH];
    logic [CNT_W-1:0] r_hdr_lat [NCH];
    logic [CNT_W-1:0] r_dat_lat [NCH];
    logic [CNT_W-1:0] r_trg_lat [NCH];
    logic [CNT_W-1:0] r_unlock  [NCH];

    logic [CNT_W-1:0] r_hdr_out;
    logic [CNT_W-1:0] r_dat_out;
    logic [CNT_W-1:0] r_trg_out;
    logic [CNT_W-1:0] r_unl_out;

    logic [NCH-1:0] w_linked;
    logic [NCH-1:0] w_hdr_ev;
    logic [NCH-1:0] w_dat_ev;
    logic [NCH-1:0] w_trg_ev;
    logic           w_wrap;
    logic           w_sat_any;

    assign w_linked = link_aligned & trig_synched;
    assign w_wrap   = enable && (r_timer == TIMER_LAST);

    // Decode per-channel event strobes from the valid/type/trigger inputs.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_hdr_ev = '0;
        w_dat_ev = '0;
        w_trg_ev = '0;
        for (int i = 0; i < NCH; i++) begin
            w_hdr_ev[i] = link_valid[i] && (link_type[2*i +: 2] == TYPE_HEADER);
            w_dat_ev[i] = link_valid[i] && (link_type[2*i +: 2] == TYPE_DATA);
            w_trg_ev[i] = trig_pulse[i];
        end
    end

    // Flag any counter currently sitting at its saturation value.
    always_comb begin
        w_sat_any = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if ((r_hdr_acc[i] == CNT_MAX) || (r_dat_acc[i] == CNT_MAX) ||
                (r_trg_acc[i] == CNT_MAX) || (r_unlock[i] == CNT_MAX))
                w_sat_any = 1'b1;
        end
    end

    // Shared window timer, end-of-window pulse and completed-window count.
    always_ff @(posedge clk40 or negedge reset) begin
        if (!reset) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_timer   <= '0;
            r_tick    <= 1'b0;
            r_refresh <= '0;
        end else if (clr) begin
            r_timer   <= '0;
            r_tick    <= 1'b0;
            r_refresh <= '0;
        end else begin
            r_tick <= w_wrap;
            if (enable) begin
                if (w_wrap) begin
                    r_timer   <= '0;
                    r_refresh <= r_refresh + REFRESH_W'(1);
                end else begin
                    r_timer <= r_timer + TIMER_W'(1);
                end
            end
        end
    end

    // Lock tracking: registered lock mask doubles as the previous-cycle
    // value for detecting 1->0 transitions; unlock counts ignore enable.
    always_ff @(posedge clk40 or negedge reset) begin
        if (!reset) begin
            r_locked_mask <= '0;
            for (int i = 0; i < NCH; i++) r_unlock[i] <= '0;
        end else if (clr) begin
            r_locked_mask <= '0;
            for (int i = 0; i < NCH; i++) r_unlock[i] <= '0;
        end else begin
            r_locked_mask <= w_linked;
            for (int i = 0; i < NCH; i++)
                r_unlock[i] <= sat_inc(r_unlock[i], r_locked_mask[i] && !w_linked[i]);
        end
    end

    // Per-channel window accumulators and latched counts. An event on the
    // wrap cycle seeds the new window rather than closing the old one.
    always_ff @(posedge clk40 or negedge reset) begin
        if (!reset) begin
            // NOTE: these small arrays are flops, not RAM, and must read 0 out of reset, so each entry is reset.
            for (int i = 0; i < NCH; i++) begin
                r_hdr_acc[i] <= '0;
                r_dat_acc[i] <= '0;
                r_trg_acc[i] <= '0;
                r_hdr_lat[i] <= '0;
                r_dat_lat[i] <= '0;
                r_trg_lat[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                r_hdr_acc[i] <= '0;
                r_dat_acc[i] <= '0;
                r_trg_acc[i] <= '0;
                r_hdr_lat[i] <= '0;
                r_dat_lat[i] <= '0;
                r_trg_lat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!w_linked[i]) begin
                    r_hdr_acc[i] <= '0;
                    r_dat_acc[i] <= '0;
                    r_trg_acc[i] <= '0;
                    r_hdr_lat[i] <= '0;
                    r_dat_lat[i] <= '0;
                    r_trg_lat[i] <= '0;
                end else if (enable) begin
                    if (w_wrap) begin
                        r_hdr_lat[i] <= r_hdr_acc[i];
                        r_dat_lat[i] <= r_dat_acc[i];
                        r_trg_lat[i] <= r_trg_acc[i];
                        r_hdr_acc[i] <= CNT_W'(w_hdr_ev[i]);
                        r_dat_acc[i] <= CNT_W'(w_dat_ev[i]);
                        r_trg_acc[i] <= CNT_W'(w_trg_ev[i]);
                    end else begin
                        r_hdr_acc[i] <= sat_inc(r_hdr_acc[i], w_hdr_ev[i]);
                        r_dat_acc[i] <= sat_inc(r_dat_acc[i], w_dat_ev[i]);
                        r_trg_acc[i] <= sat_inc(r_trg_acc[i], w_trg_ev[i]);
                    end
                end
            end
        end
    end

    // Sticky saturation flag.
    always_ff @(posedge clk40 or negedge reset) begin
        if (!reset)
            r_any_sat <= 1'b0;
        else if (clr)
            r_any_sat <= 1'b0;
        else
            r_any_sat <= r_any_sat | w_sat_any;
    end

    // Registered output mux for the selected channel; out-of-range selects read 0.
    always_ff @(posedge clk40 or negedge reset) begin
        if (!reset) begin
            r_hdr_out <= '0;
            r_dat_out <= '0;
            r_trg_out <= '0;
            r_unl_out <= '0;
        end else if (clr) begin
            r_hdr_out <= '0;
            r_dat_out <= '0;
            r_trg_out <= '0;
            r_unl_out <= '0;
        end else begin
            r_hdr_out <= '0;
            r_dat_out <= '0;
            r_trg_out <= '0;
            r_unl_out <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (ch_sel == SEL_W'(i)) begin
                    r_hdr_out <= r_hdr_lat[i];
                    r_dat_out <= r_dat_lat[i];
                    r_trg_out <= r_trg_lat[i];
                    r_unl_out <= r_unlock[i];
                end
            end
        end
    end

    assign header_count  = r_hdr_out;
    assign data_count    = r_dat_out;
    assign trig_count    = r_trg_out;
    assign unlock_count  = r_unl_out;
    assign refresh_count = r_refresh;
    assign tick          = r_tick;
    assign locked_mask   = r_locked_mask;
    assign any_saturated = r_any_sat;

endmodule

// File: tb/tb_etroc_multi_link_monitor.sv
// Directed bench for etroc_multi_link_monitor (NCH=4, CNT_W=8, TICK_CLOCKS=100).
// A second instance with a 400-cycle window exercises counter saturation.
module tb_etroc_multi_link_monitor;

    logic       clk40;
    logic       reset;
    logic       clr;
    logic       enable;
    logic [1:0] ch_sel;
    logic [3:0] link_valid;
    logic [7:0] link_type;
    logic [3:0] link_aligned;
    logic [3:0] trig_synched;
    logic [3:0] trig_pulse;
    logic [7:0]  header_count, data_count, trig_count, unlock_count;
    logic [15:0] refresh_count;
    logic        tick;
    logic [3:0]  locked_mask;
    logic        any_saturated;

    logic       s_clr;
    logic       s_en;
    logic [3:0] s_valid;
    logic [7:0] s_type;
    logic [7:0]  s_header, s_data, s_trig, s_unlock;
    logic [15:0] s_refresh;
    logic        s_tick;
    logic [3:0]  s_locked;
    logic        s_any_sat;

    int tests_run = 0;
    int tests_failed = 0;
    int first_tick;
    int n;

    etroc_multi_link_monitor #(
        .NCH(4), .CNT_W(8), .TICK_CLOCKS(100), .REFRESH_W(16), .SEL_W(2)
    ) u_dut (
        .clk40(clk40), .reset(reset), .clr(clr), .enable(enable), .ch_sel(ch_sel),
        .link_valid(link_valid), .link_type(link_type), .link_aligned(link_aligned),
        .trig_synched(trig_synched), .trig_pulse(trig_pulse),
        .header_count(header_count), .data_count(data_count), .trig_count(trig_count),
        .unlock_count(unlock_count), .refresh_count(refresh_count), .tick(tick),
        .locked_mask(locked_mask), .any_saturated(any_saturated)
    );

    etroc_multi_link_monitor #(
        .NCH(4), .CNT_W(8), .TICK_CLOCKS(400), .REFRESH_W(16), .SEL_W(2)
    ) u_sat (
        .clk40(clk40), .reset(reset), .clr(s_clr), .enable(s_en), .ch_sel(2'd0),
        .link_valid(s_valid), .link_type(s_type), .link_aligned(4'hF),
        .trig_synched(4'hF), .trig_pulse(4'h0),
        .header_count(s_header), .data_count(s_data), .trig_count(s_trig),
        .unlock_count(s_unlock), .refresh_count(s_refresh), .tick(s_tick),
        .locked_mask(s_locked), .any_saturated(s_any_sat)
    );

    initial begin
        clk40 = 1'b0;
        forever #5 clk40 = ~clk40;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk40);
        #1;
    endtask

    task automatic idle_inputs();
        link_valid = '0;
        link_type  = '1;
        trig_pulse = '0;
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; enable = 1'b1; ch_sel = 2'd0;
        link_aligned = 4'hF; trig_synched = 4'hF;
        idle_inputs();
        s_clr = 1'b0; s_en = 1'b0; s_valid = '0; s_type = '1;

        // Reset state, then release between edges.
        repeat (2) @(posedge clk40);
        #3;
        check("rst_header", header_count, 0);
        check("rst_refresh", refresh_count, 0);
        check("rst_tick", tick, 0);
        check("rst_locked", locked_mask, 0);
        reset = 1'b1;

        // Window 1: 10 headers, 20 data, 3 triggers on ch0; data on the wrap cycle.
        first_tick = 0;
        for (int c = 0; c < 100; c++) begin
            idle_inputs();
            if (c < 10) begin
                link_valid[0] = 1'b1; link_type[1:0] = 2'b00;
            end else if (c < 30) begin
                link_valid[0] = 1'b1; link_type[1:0] = 2'b01;
            end else if (c < 33) begin
                trig_pulse[0] = 1'b1;
            end else if (c == 99) begin
                link_valid[0] = 1'b1; link_type[1:0] = 2'b01;
            end
            step();
            if (c == 0) check("locked_latency", locked_mask, 4'hF);
            if (tick && first_tick == 0) first_tick = c + 1;
        end
        idle_inputs();
        check("first_tick_edge", first_tick, 100);
        step();
        check("w1_header", header_count, 10);
        check("w1_data", data_count, 20);
        check("w1_trig", trig_count, 3);
        check("w1_refresh", refresh_count, 1);
        check("w1_tick_low", tick, 0);

        // Window 2: only the wrap-cycle data word.
        repeat (98) step();
        check("w2_pre_tick", tick, 0);
        step();
        check("w2_tick", tick, 1);
        step();
        check("w2_data_carry", data_count, 1);
        check("w2_header", header_count, 0);
        check("w2_refresh", refresh_count, 2);

        // Window 3: ch2 loses lock twice; ch0 sees 5 data words.
        for (int c = 0; c < 99; c++) begin
            idle_inputs();
            if (c < 5) begin
                link_valid[0] = 1'b1; link_type[1:0] = 2'b01;
            end
            if (c < 3) begin
                link_valid[2] = 1'b1; link_type[5:4] = 2'b01;
            end
            if (c == 10 || c == 30) link_aligned[2] = 1'b0;
            if (c == 20 || c == 40) link_aligned[2] = 1'b1;
            step();
            if (c == 10) check("loss_locked_mask", locked_mask, 4'b1011);
        end
        idle_inputs();
        check("w3_tick", tick, 1);
        step();
        check("w3_ch0_data", data_count, 5);
        ch_sel = 2'd2;
        step();
        check("w3_ch2_data", data_count, 0);
        check("w3_ch2_header", header_count, 0);
        check("w3_ch2_unlock", unlock_count, 2);
        ch_sel = 2'd0;
        step();
        check("w3_ch0_unlock", unlock_count, 0);
        check("w3_ch0_data_again", data_count, 5);

        // Synchronous clear, then a window with 50 disabled cycles.
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_refresh", refresh_count, 0);
        check("clr_data", data_count, 0);
        first_tick = 0;
        for (int c = 0; c < 150; c++) begin
            idle_inputs();
            enable = !(c >= 20 && c < 70);
            if (c < 4 || (c >= 30 && c < 37)) begin
                link_valid[0] = 1'b1; link_type[1:0] = 2'b01;
            end
            if (c == 40) link_aligned[1] = 1'b0;
            if (c == 50) link_aligned[1] = 1'b1;
            step();
            if (tick && first_tick == 0) first_tick = c + 1;
        end
        idle_inputs();
        enable = 1'b1;
        check("disable_tick_edge", first_tick, 150);
        step();
        check("disable_data", data_count, 4);
        check("disable_refresh", refresh_count, 1);
        ch_sel = 2'd1;
        step();
        check("disable_ch1_unlock", unlock_count, 1);
        check("no_saturation", any_saturated, 0);

        // Asynchronous reset mid-window, released between edges.
        #3;
        reset = 1'b0;
        #1;
        check("async_unlock", unlock_count, 0);
        check("async_refresh", refresh_count, 0);
        check("async_locked", locked_mask, 0);
        check("async_tick", tick, 0);
        #2;
        reset = 1'b1;
        n = 0;
        while (!tick && n < 200) begin
            step();
            n++;
        end
        check("tick_after_reset", n, 100);

        // Saturation: 300 data words inside one 400-cycle window.
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        s_en  = 1'b1;
        for (int c = 0; c < 300; c++) begin
            s_valid = 4'b0001; s_type = 8'hFD;
            step();
        end
        s_valid = '0; s_type = '1;
        check("sat_flag_set", s_any_sat, 1);
        repeat (100) step();
        check("sat_tick", s_tick, 1);
        step();
        check("sat_data", s_data, 255);
        check("sat_flag_sticky", s_any_sat, 1);
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        check("sat_flag_clr", s_any_sat, 0);
        check("sat_data_clr", s_data, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
